sfp_send_scheduler: RTL and testbench
=====================================

// Module: sfp_send_scheduler
// PURPOSE
//  Multi-channel packet-send scheduler for the SFP/TSE test platform. Generates per-channel
//  cmd_send strobes and start RAM addresses toward the send_packet_N_control conduits.
//  Supports three sources of sends: periodic, echo (resend whenever receive side saved a
//  packet), and kick-then-echo. Sits in sfp_test_top between system_design and channel logic.
// PARAMETERS
//  NUM_CH     4   number of independent channels
//  ADDR_W     25  width of start RAM address
//  CNT_W      32  width of period counter / period inputs
//  PULSE_LEN  4   cycles cmd_send is held high for a periodic/kick send (>=1)
//  TXCNT_W    16  width of per-channel sent-packet counter
// PORTS
//  clk_50          in   1              system clock (clk_50_pll domain)
//  rst_n           in   1              asynchronous active-low reset
//  link_ok         in   1              mac_inited & rx_ready; gates all scheduling
//  ch_mode         in   2*NUM_CH       per-channel: 00 off, 01 periodic, 10 echo, 11 kick-then-echo
//  ch_period       in   CNT_W*NUM_CH   per-channel period in clk_50 cycles
//  ch_start_addr   in   ADDR_W*NUM_CH  per-channel RAM address to send from
//  data_saved      in   NUM_CH         receive_packet_N data_saved level
//  cnt_clr         in   1              synchronous clear of all tx_count
//  cmd_send        out  NUM_CH         send command to send_packet_N_control
//  start_ram_addr  out  ADDR_W*NUM_CH  address latched at cmd_send assertion
//  tx_count        out  TXCNT_W*NUM_CH rising edges of cmd_send, saturating
// BEHAVIOUR
//  Reset (rst_n low, async): cmd_send=0, start_ram_addr=0, tx_count=0, counters=0,
//   kick_done=0, all channels in IDLE.
//  Per-channel FSM: IDLE -> COUNT -> PULSE -> COUNT ... ; ECHO for modes 10 and post-kick 11.
//  IDLE: cmd_send=0, counter=0. Leaves IDLE when link_ok=1 and mode!=00:
//   mode 01 / (11 & !kick_done) -> COUNT; mode 10 / (11 & kick_done) -> ECHO.
//  COUNT: counter increments each cycle; on counter==eff_period-1 -> PULSE, counter
//   reloads 0 (counter keeps running during PULSE, so period is edge-to-edge).
//  eff_period = max(ch_period, PULSE_LEN+1); ch_period==0 means no periodic send (stay COUNT
//   with counter held at 0).
//  PULSE: cmd_send high exactly PULSE_LEN cycles; start_ram_addr latched from ch_start_addr
//   on the cycle cmd_send rises and held until next assertion. Mode 01 -> back to COUNT;
//   mode 11 -> set kick_done, go to ECHO.
//  ECHO: cmd_send registered from data_saved: rises the cycle after data_saved seen high
//   while cmd_send low (address latched then); falls the cycle after data_saved seen low.
//   1-cycle latency each direction.
//  Latency: first periodic cmd_send high on the clock edge eff_period edges after the first
//   edge sampling link_ok=1 in COUNT; subsequent rising edges every eff_period cycles.
//  link_ok falling: every channel -> IDLE next edge, cmd_send=0, counter=0, PULSE aborted,
//   kick_done cleared; start_ram_addr and tx_count retained.
//  ch_mode change on a channel: that channel -> IDLE next edge (same as above, local only);
//   other channels unaffected. ch_period change takes effect at next compare.
//  tx_count: +1 per cmd_send rising edge, saturates at all-ones. cnt_clr wins over
//   simultaneous increment (result 0). Aborted pulses still counted once.
//  Channels fully independent; simultaneous sends on all channels allowed.
// TESTING
//  1 PULSE_LEN=4, ch0 mode01 period=8, link_ok=1 at edge 0 -> cmd_send[0] high edges 8-11,
//    next rise edge 16; start_ram_addr[0]=ch_start_addr[0]=1; tx_count[0]=2 after edge 16.
//  2 ch1 mode11 period=10, data_saved[1] pulsed high 5 cycles at edge 30 -> kick pulse
//    edges 10-13, then cmd_send[1] high edges 31-35, tx_count[1]=2.
//  3 ch2 mode01 period=2 (PULSE_LEN=4) -> clamp: rises every 5 cycles, high 4, low 1.
//  4 link_ok dropped at edge 9 during ch0 pulse -> cmd_send[0]=0 at edge 10, restored link
//    at edge 20 -> next rise at edge 28; tx_count unchanged by the drop.
//  5 tx_count at 0xFFFF with another send -> stays 0xFFFF; cnt_clr with rising edge -> 0.
//  6 async rst_n low mid-pulse, no clock -> all outputs 0 immediately; mode00 channel never
//    asserts cmd_send regardless of data_saved.

Source files
------------

// File: rtl/sfp_send_scheduler.sv
// Multi-channel send scheduler: per-channel periodic, echo and kick-then-echo cmd_send
// generation with start-address latch and saturating sent-packet counter.

module sfp_send_ch #(
   parameter int ADDR_W    = 25,
   parameter int CNT_W     = 32,
   parameter int PULSE_LEN = 4,
   parameter int TXCNT_W   = 16
) (
   input  logic               i_clk_50,
   input  logic               i_rst_n,
   input  logic               i_link_ok,
   input  logic [1:0]         i_mode,
   input  logic [CNT_W-1:0]   i_period,
   input  logic [ADDR_W-1:0]  i_start_addr,
   input  logic               i_data_saved,
   input  logic               i_cnt_clr,
   output logic               o_cmd_send,
   output logic [ADDR_W-1:0]  o_start_ram_addr,
   output logic [TXCNT_W-1:0] o_tx_count
);

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PULSE, S_ECHO} state_t;

   localparam logic [CNT_W-1:0] MIN_PER    = CNT_W'(PULSE_LEN + 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
   localparam logic [1:0]       M_OFF      = 2'b00;
   localparam logic [1:0]       M_PER      = 2'b01;
   localparam logic [1:0]       M_KICK     = 2'b11;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic                r_cmd, w_cmd_nxt;
   logic                r_kick_done, w_kick_nxt;
   logic [1:0]          r_mode_q;
   logic [ADDR_W-1:0]   r_addr;
   logic [TXCNT_W-1:0]  r_tx;
   logic                w_per_zero;
   logic [CNT_W-1:0]    w_eff_last;
   logic                w_rise;

   // Period is clamped so the next compare can never land inside the pulse.
   assign w_per_zero = (i_period == '0);
   assign w_eff_last = ((i_period < MIN_PER) ? MIN_PER : i_period) - CNT_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cmd_nxt   = r_cmd;
      w_kick_nxt  = r_kick_done;
      if (!i_link_ok || (i_mode != r_mode_q)) begin
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_cmd_nxt   = 1'b0;
         w_kick_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_nxt = '0;
               w_cmd_nxt = 1'b0;
               if ((i_mode == M_PER) || ((i_mode == M_KICK) && !r_kick_done))
                  w_state_nxt = S_COUNT;
               else if (i_mode != M_OFF)
                  w_state_nxt = S_ECHO;
            end
            S_COUNT: begin
               if (w_per_zero) begin
                  w_cnt_nxt = '0;
               end else if (r_cnt >= w_eff_last) begin
                  w_state_nxt = S_PULSE;
                  w_cnt_nxt   = '0;
                  w_cmd_nxt   = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            S_PULSE: begin
               // Counter keeps running through the pulse so the period is edge-to-edge.
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (r_cnt >= PULSE_LAST) begin
                  w_cmd_nxt = 1'b0;
                  if (i_mode == M_KICK) begin
                     w_kick_nxt  = 1'b1;
                     w_state_nxt = S_ECHO;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_state_nxt = S_COUNT;
                     if (w_per_zero) w_cnt_nxt = '0;
                  end
               end
            end
            S_ECHO: begin
               w_cnt_nxt = '0;
               w_cmd_nxt = i_data_saved;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_cmd_nxt   = 1'b0;
            end
         endcase
      end
   end

   assign w_rise = w_cmd_nxt & ~r_cmd;

   always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_cmd       <= 1'b0;
         r_kick_done <= 1'b0;
         r_mode_q    <= '0;
         r_addr      <= '0;
         r_tx        <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cmd       <= w_cmd_nxt;
         r_kick_done <= w_kick_nxt;
         r_mode_q    <= i_mode;
         if (w_rise) r_addr <= i_start_addr;
         if (i_cnt_clr)
            r_tx <= '0;
         else if (w_rise && (r_tx != '1))
            r_tx <= r_tx + TXCNT_W'(1);
      end
   end

   assign o_cmd_send       = r_cmd;
   assign o_start_ram_addr = r_addr;
   assign o_tx_count       = r_tx;

endmodule

module sfp_send_scheduler #(
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 25,
   parameter int CNT_W     = 32,
   parameter int PULSE_LEN = 4,
   parameter int TXCNT_W   = 16
) (
   input  logic                             i_clk_50,
   input  logic                             i_rst_n,
   input  logic                             i_link_ok,
   input  logic [NUM_CH-1:0][1:0]           i_ch_mode,
   input  logic [NUM_CH-1:0][CNT_W-1:0]     i_ch_period,
   input  logic [NUM_CH-1:0][ADDR_W-1:0]    i_ch_start_addr,
   input  logic [NUM_CH-1:0]                i_data_saved,
   input  logic                             i_cnt_clr,
   output logic [NUM_CH-1:0]                o_cmd_send,
   output logic [NUM_CH-1:0][ADDR_W-1:0]    o_start_ram_addr,
   output logic [NUM_CH-1:0][TXCNT_W-1:0]   o_tx_count
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      sfp_send_ch #(
         .ADDR_W    (ADDR_W),
         .CNT_W     (CNT_W),
         .PULSE_LEN (PULSE_LEN),
         .TXCNT_W   (TXCNT_W)
      ) u_ch (
         .i_clk_50         (i_clk_50),
         .i_rst_n          (i_rst_n),
         .i_link_ok        (i_link_ok),
         .i_mode           (i_ch_mode[g]),
         .i_period         (i_ch_period[g]),
         .i_start_addr     (i_ch_start_addr[g]),
         .i_data_saved     (i_data_saved[g]),
         .i_cnt_clr        (i_cnt_clr),
         .o_cmd_send       (o_cmd_send[g]),
         .o_start_ram_addr (o_start_ram_addr[g]),
         .o_tx_count       (o_tx_count[g])
      );
   end

endmodule

// File: tb/tb_sfp_send_scheduler.sv
// Directed bench for sfp_send_scheduler; edge e=0 is the first edge sampling link_ok=1.
module tb_sfp_send_scheduler;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              link;
   logic              cnt_clr;
   logic [3:0][1:0]   mode;
   logic [3:0][31:0]  period;
   logic [3:0][24:0]  addr;
   logic [3:0]        ds;
   logic [3:0]        cmd;
   logic [3:0][24:0]  sram;
   logic [3:0][15:0]  tx;

   logic [0:0][1:0]   s_mode;
   logic [0:0][31:0]  s_period;
   logic [0:0][24:0]  s_addr;
   logic [0:0]        s_ds;
   logic [0:0]        s_cmd;
   logic [0:0][24:0]  s_sram;
   logic [0:0][3:0]   s_tx;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sfp_send_scheduler u_dut (
      .i_clk_50(clk), .i_rst_n(rst_n), .i_link_ok(link), .i_ch_mode(mode),
      .i_ch_period(period), .i_ch_start_addr(addr), .i_data_saved(ds),
      .i_cnt_clr(cnt_clr), .o_cmd_send(cmd), .o_start_ram_addr(sram), .o_tx_count(tx));

   // Small counter width so saturation is reachable quickly.
   sfp_send_scheduler #(.NUM_CH(1), .TXCNT_W(4)) u_sat (
      .i_clk_50(clk), .i_rst_n(rst_n), .i_link_ok(link), .i_ch_mode(s_mode),
      .i_ch_period(s_period), .i_ch_start_addr(s_addr), .i_data_saved(s_ds),
      .i_cnt_clr(cnt_clr), .o_cmd_send(s_cmd), .o_start_ram_addr(s_sram), .o_tx_count(s_tx));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; link = 1'b0; cnt_clr = 1'b0;
      mode = '0; period = '0; addr = '0; ds = '0;
      s_mode = '0; s_period = '0; s_addr = '0; s_ds = '0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic start_link();
      tick(); tick();
      link = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (cmd !== 4'h0 || sram !== '0 || tx !== '0 || s_cmd !== 1'b0 || s_tx !== '0) begin
         failures++;
         $display("FAIL reset_state cmd=%0h tx=%0h s_tx=%0h exp all zero", cmd, tx, s_tx);
      end
   endtask

   task automatic test_periodic();
      do_reset();
      mode[0] = 2'b01; period[0] = 32'd8; addr[0] = 25'd1;
      start_link();
      for (int e = 0; e <= 16; e++) begin
         tick();
         checks++;
         if (cmd[0] !== ((e >= 8 && e <= 11) || e == 16)) begin
            failures++;
            $display("FAIL periodic_cmd e=%0d got=%0b", e, cmd[0]);
         end
         if (e == 12) addr[0] = 25'd7;
         if (e == 15) begin
            checks++;
            if (sram[0] !== 25'd1) begin
               failures++;
               $display("FAIL periodic_addr_hold got=%0h exp=1", sram[0]);
            end
         end
      end
      checks++;
      if (sram[0] !== 25'd7 || tx[0] !== 16'd2) begin
         failures++;
         $display("FAIL periodic_latch addr=%0h tx=%0d exp addr=7 tx=2", sram[0], tx[0]);
      end
   endtask

   task automatic test_kick_echo();
      do_reset();
      mode[1] = 2'b11; period[1] = 32'd10; addr[1] = 25'h55;
      start_link();
      for (int e = 0; e <= 40; e++) begin
         tick();
         checks++;
         if (cmd[1] !== ((e >= 10 && e <= 13) || (e >= 31 && e <= 35))) begin
            failures++;
            $display("FAIL kick_echo_cmd e=%0d got=%0b", e, cmd[1]);
         end
         if (e == 13) begin
            checks++;
            if (sram[1] !== 25'h55) begin
               failures++;
               $display("FAIL kick_addr got=%0h exp=55", sram[1]);
            end
         end
         if (e == 3)  ds[1] = 1'b1;
         if (e == 5)  ds[1] = 1'b0;
         if (e == 25) addr[1] = 25'h66;
         if (e == 30) ds[1] = 1'b1;
         if (e == 35) ds[1] = 1'b0;
      end
      checks++;
      if (tx[1] !== 16'd2 || sram[1] !== 25'h66) begin
         failures++;
         $display("FAIL echo_count tx=%0d addr=%0h exp tx=2 addr=66", tx[1], sram[1]);
      end
   endtask

   task automatic test_clamp();
      do_reset();
      mode[2] = 2'b01; period[2] = 32'd2;
      mode[0] = 2'b01; period[0] = 32'd5;
      start_link();
      for (int e = 0; e <= 25; e++) begin
         tick();
         checks++;
         if (cmd[2] !== (e >= 5 && (e % 5) != 4) || cmd[0] !== (e >= 5 && (e % 5) != 4)) begin
            failures++;
            $display("FAIL clamp_cmd e=%0d got ch2=%0b ch0=%0b", e, cmd[2], cmd[0]);
         end
      end
   endtask

   task automatic test_link_drop();
      do_reset();
      mode[0] = 2'b01; period[0] = 32'd8; addr[0] = 25'h3;
      start_link();
      for (int e = 0; e <= 30; e++) begin
         tick();
         checks++;
         if (cmd[0] !== (e == 8 || e == 9 || e >= 28)) begin
            failures++;
            $display("FAIL link_drop_cmd e=%0d got=%0b", e, cmd[0]);
         end
         if (e == 15 || e == 28) begin
            checks++;
            if (tx[0] !== ((e == 15) ? 16'd1 : 16'd2) || sram[0] !== 25'h3) begin
               failures++;
               $display("FAIL link_drop_keep e=%0d tx=%0d addr=%0h", e, tx[0], sram[0]);
            end
         end
         if (e == 9)  link = 1'b0;
         if (e == 19) link = 1'b1;
      end
   endtask

   task automatic test_mode_change();
      do_reset();
      mode[0] = 2'b01; period[0] = 32'd8;
      mode[1] = 2'b01; period[1] = 32'd8;
      start_link();
      for (int e = 0; e <= 22; e++) begin
         tick();
         checks++;
         if (cmd[0] !== (e == 8 || e == 9 || e >= 21) ||
             cmd[1] !== ((e >= 8 && e <= 11) || (e >= 16 && e <= 19))) begin
            failures++;
            $display("FAIL mode_change_cmd e=%0d got ch0=%0b ch1=%0b", e, cmd[0], cmd[1]);
         end
         if (e == 9)  mode[0] = 2'b10;
         if (e == 20) ds[0] = 1'b1;
      end
      checks++;
      if (tx[0] !== 16'd2 || tx[1] !== 16'd2) begin
         failures++;
         $display("FAIL mode_change_tx got ch0=%0d ch1=%0d exp 2 2", tx[0], tx[1]);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      s_mode[0] = 2'b10;
      link = 1'b1;
      tick(); tick(); tick();
      for (int n = 1; n <= 16; n++) begin
         s_ds[0] = 1'b1; tick();
         s_ds[0] = 1'b0; tick();
         if (n >= 15) begin
            checks++;
            if (s_tx[0] !== 4'hF) begin
               failures++;
               $display("FAIL saturate n=%0d got=%0h exp=f", n, s_tx[0]);
            end
         end
      end
      s_ds[0] = 1'b1; cnt_clr = 1'b1; tick();
      checks++;
      if (s_tx[0] !== 4'h0 || s_cmd[0] !== 1'b1) begin
         failures++;
         $display("FAIL clr_wins got tx=%0h cmd=%0b exp tx=0 cmd=1", s_tx[0], s_cmd[0]);
      end
      cnt_clr = 1'b0; s_ds[0] = 1'b0; tick();
      s_ds[0] = 1'b1; tick();
      checks++;
      if (s_tx[0] !== 4'h1) begin
         failures++;
         $display("FAIL count_after_clr got=%0h exp=1", s_tx[0]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      mode[0] = 2'b01; period[0] = 32'd8; addr[0] = 25'h1AB;
      mode[3] = 2'b00; ds[3] = 1'b1;
      start_link();
      for (int e = 0; e <= 9; e++) begin
         tick();
         checks++;
         if (cmd[3] !== 1'b0) begin
            failures++;
            $display("FAIL mode_off_cmd e=%0d got=%0b exp=0", e, cmd[3]);
         end
      end
      checks++;
      if (cmd[0] !== 1'b1 || tx[0] !== 16'd1) begin
         failures++;
         $display("FAIL pre_reset_pulse cmd=%0b tx=%0d exp cmd=1 tx=1", cmd[0], tx[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (cmd !== 4'h0 || sram !== '0 || tx !== '0) begin
         failures++;
         $display("FAIL async_reset cmd=%0h addr0=%0h tx0=%0d exp all zero", cmd, sram[0], tx[0]);
      end
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_periodic();
      test_kick_echo();
      test_clamp();
      test_link_drop();
      test_mode_change();
      test_saturate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
